// File: rtl/shift_feed_buf_if.sv
// shift_feed_buf_if
//   Bundles the producer handshake and the shift-stage feed signals of
//   shift_feed_buf so they can be passed around as one port.
//
//   Producer side : s_valid, s_data  -> buffer
//                   s_ready          <- buffer
//   Shift side    : sh_en, sh_data   <- buffer (registered word + strobe)
//   Status        : level, busy, drained <- buffer
//
//   master : the producer / observer of the buffer
//   slave  : the buffer itself
interface shift_feed_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             sh_en;
  logic [WIDTH-1:0] sh_data;
  logic [LW-1:0]    level;
  logic             busy;
  logic             drained;

  modport master (
    output s_valid, s_data,
    input  s_ready, sh_en, sh_data, level, busy, drained
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, sh_en, sh_data, level, busy, drained
  );
endinterface

// File: rtl/shift_feed_buf.sv
// shift_feed_buf
//   Upstream feeder for the shift register stage. Producer words are
//   accepted over a valid/ready handshake into a small circular FIFO. Once
//   THRESH words are buffered the block drains them back-to-back, one per
//   cycle, as sh_data plus an sh_en strobe. Words pushed while draining
//   extend the burst, so bursty input becomes contiguous enabled bursts.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset; discards buffered words and
//            aborts any burst in progress
//     bus  - shift_feed_buf_if.slave
//            s_valid/s_data/s_ready : producer handshake (s_ready is
//                                     combinational, low while rst)
//            sh_en/sh_data          : registered feed to the shift stage
//            level                  : registered buffered-word count
//            busy                   : high while draining
//            drained                : one-cycle pulse after a burst empties
//                                     the buffer
module shift_feed_buf #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  shift_feed_buf_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_THR  = LW'(THRESH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  state_t           state_q;
  logic             sh_en_q;
  logic [WIDTH-1:0] sh_data_q;
  logic             busy_q;
  logic             drained_q;

  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic             last_pop_s;

  // Handshake decode and next-state for pointers and level.
  always_comb begin
    ready_s    = (level_q != LVL_FULL) && !rst;
    push_s     = bus.s_valid && ready_s;
    pop_s      = (state_q == ST_DRAIN) && (level_q != LVL_ZERO);
    // The burst ends only when the final word leaves and nothing refills it.
    last_pop_s = pop_s && (level_q == LVL_ONE) && !push_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous push and pop leave the count unchanged.
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.s_data;
    end
  end

  // Pointer, level and output-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      level_q   <= LVL_ZERO;
      sh_en_q   <= 1'b0;
      sh_data_q <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sh_en_q  <= pop_s;
      if (pop_s) begin
        sh_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Burst FSM with registered busy and drained outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drained_q <= 1'b0;
          // Uses the registered level, so a push on this edge cannot start it.
          if (level_q >= LVL_THR) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (last_pop_s) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            drained_q <= 1'b1;
          end else begin
            state_q   <= ST_DRAIN;
            busy_q    <= 1'b1;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = ready_s;
  assign bus.sh_en   = sh_en_q;
  assign bus.sh_data = sh_data_q;
  assign bus.level   = level_q;
  assign bus.busy    = busy_q;
  assign bus.drained = drained_q;

endmodule

// File: tb/tb_shift_feed_buf.sv
// Testbench for shift_feed_buf. Instance A (DEPTH 8, THRESH 4) is checked
// every cycle against a queue-based model; instance B (DEPTH 8, THRESH 8)
// covers the full-before-burst case with directed checks.
module tb_shift_feed_buf;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int TA = 4;
  localparam int TB = 8;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  shift_feed_buf_if #(.WIDTH(W), .DEPTH(D)) if_a ();
  shift_feed_buf_if #(.WIDTH(W), .DEPTH(D)) if_b ();

  shift_feed_buf #(.WIDTH(W), .DEPTH(D), .THRESH(TA)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a)
  );

  shift_feed_buf #(.WIDTH(W), .DEPTH(D), .THRESH(TB)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of instance A ----------------
  logic [W-1:0] mq[$];
  bit           m_valid   = 1'b0;
  bit           m_drain   = 1'b0;
  bit           m_en      = 1'b0;
  logic [W-1:0] m_data    = '0;
  bit           m_drained = 1'b0;
  bit           m_pushed  = 1'b0;

  always @(posedge clk) begin
    int n;
    bit do_push, do_pop;
    if (rst_a) begin
      mq.delete();
      m_drain = 1'b0; m_en = 1'b0; m_data = '0;
      m_drained = 1'b0; m_pushed = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      n = mq.size();
      do_pop  = m_drain && (n > 0);
      do_push = (if_a.s_valid === 1'b1) && (n != D);
      m_drained = do_pop && (n == 1) && !do_push;
      if (!m_drain) m_drain = (n >= TA);
      else if (m_drained) m_drain = 1'b0;
      m_en = do_pop;
      if (do_pop) m_data = mq.pop_front();
      if (do_push) mq.push_back(if_a.s_data);
      m_pushed = do_push;
    end
  end

  // ---------------- per-cycle compare of instance A ----------------
  logic [W-1:0] out_log[$];
  int           drain_cnt = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("s_ready", 64'(if_a.s_ready), 64'(((mq.size() != D) && !rst_a) ? 1 : 0));
      chk("level",   64'(if_a.level),   64'(mq.size()));
      chk("sh_en",   64'(if_a.sh_en),   64'(m_en));
      chk("sh_data", 64'(if_a.sh_data), 64'(m_data));
      chk("busy",    64'(if_a.busy),    64'(m_drain));
      chk("drained", 64'(if_a.drained), 64'(m_drained));
      if (if_a.sh_en === 1'b1) out_log.push_back(if_a.sh_data);
      if (if_a.drained === 1'b1) drain_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int stall_cnt = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Present a word and hold it until the model sees it accepted.
  task automatic push_word(input logic [W-1:0] w);
    int t;
    if_a.s_valid = 1'b1;
    if_a.s_data  = w;
    t = 0;
    do begin
      cyc(1);
      t++;
    end while (!m_pushed && t < 50);
    if (t > 1) stall_cnt++;
    if (!m_pushed) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %0h not accepted within 50 cycles", w);
    end
  endtask

  initial begin
    int base, d0, t;
    logic [W-1:0] exp_burst[4];
    exp_burst[0] = 32'h11; exp_burst[1] = 32'h22;
    exp_burst[2] = 32'h33; exp_burst[3] = 32'h44;

    if_a.s_valid = 1'b0; if_a.s_data = '0;
    if_b.s_valid = 1'b0; if_b.s_data = '0;

    // Reset then idle
    cyc(2);
    rst_a = 1'b0;
    cyc(10);
    chk("idle_level", 64'(if_a.level), 64'd0);
    chk("idle_ready", 64'(if_a.s_ready), 64'd1);
    chk("idle_data",  64'(if_a.sh_data), 64'd0);

    // Threshold burst with latency pins
    base = out_log.size(); d0 = drain_cnt;
    for (int i = 0; i < 4; i++) push_word(exp_burst[i]);
    if_a.s_valid = 1'b0;
    chk("busy_at_e", 64'(if_a.busy), 64'd0);
    cyc(1);
    chk("busy_at_e1", 64'(if_a.busy), 64'd1);
    chk("en_at_e1",   64'(if_a.sh_en), 64'd0);
    cyc(1);
    chk("en_at_e2",   64'(if_a.sh_en), 64'd1);
    chk("data_at_e2", 64'(if_a.sh_data), 64'h11);
    cyc(10);
    chk("burst_cnt", 64'(out_log.size() - base), 64'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < out_log.size()) chk("burst_word", 64'(out_log[base+i]), 64'(exp_burst[i]));
    chk("burst_drained", 64'(drain_cnt - d0), 64'd1);
    chk("burst_level", 64'(if_a.level), 64'd0);

    // Below threshold, then the fourth word triggers the burst
    base = out_log.size(); d0 = drain_cnt;
    for (int i = 0; i < 3; i++) push_word(32'hA1 + 32'(i));
    if_a.s_valid = 1'b0;
    cyc(10);
    chk("below_level", 64'(if_a.level), 64'd3);
    chk("below_busy",  64'(if_a.busy), 64'd0);
    chk("below_out",   64'(out_log.size() - base), 64'd0);
    push_word(32'hA4);
    if_a.s_valid = 1'b0;
    cyc(12);
    chk("below_burst", 64'(out_log.size() - base), 64'd4);
    chk("below_drained", 64'(drain_cnt - d0), 64'd1);

    // Sustained streams: 12 words, then 20 words
    for (int s = 0; s < 2; s++) begin
      int nw;
      logic [W-1:0] b;
      nw = (s == 0) ? 12 : 20;
      b  = (s == 0) ? 32'h100 : 32'h300;
      base = out_log.size(); d0 = drain_cnt; stall_cnt = 0;
      for (int i = 0; i < nw; i++) push_word(b + 32'(i));
      if_a.s_valid = 1'b0;
      cyc(20);
      chk("stream_cnt", 64'(out_log.size() - base), 64'(nw));
      for (int i = 0; i < nw; i++)
        if (base + i < out_log.size()) chk("stream_word", 64'(out_log[base+i]), 64'(b + 32'(i)));
      chk("stream_stall", 64'(stall_cnt), 64'd0);
      chk("stream_drained", 64'(drain_cnt - d0), 64'd1);
    end

    // Reset mid-burst
    for (int i = 0; i < 4; i++) push_word(32'h51 + 32'(i));
    if_a.s_valid = 1'b0;
    base = out_log.size();
    t = 0;
    while (out_log.size() - base < 2 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("midrst_reach2", 64'(out_log.size() - base), 64'd2);
    rst_a = 1'b1;
    cyc(1);
    chk("midrst_en",      64'(if_a.sh_en), 64'd0);
    chk("midrst_level",   64'(if_a.level), 64'd0);
    chk("midrst_busy",    64'(if_a.busy), 64'd0);
    chk("midrst_drained", 64'(if_a.drained), 64'd0);
    rst_a = 1'b0;
    cyc(10);
    chk("midrst_total", 64'(out_log.size() - base), 64'd2);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if (!(if_a.s_valid && !m_pushed)) begin
        if_a.s_valid = ($urandom_range(0, 99) < 60);
        if_a.s_data  = $urandom;
      end
      rst_a = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    if_a.s_valid = 1'b0;
    rst_a = 1'b0;
    cyc(20);

    // Instance B: THRESH == DEPTH, burst only starts when full
    rst_b = 1'b0;
    if_b.s_valid = 1'b1;
    if_b.s_data  = 32'h2AA;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk("b_level", 64'(if_b.level), 64'(i));
      chk("b_ready", 64'(if_b.s_ready), 64'((i < 8) ? 1 : 0));
      chk("b_busy",  64'(if_b.busy), 64'd0);
    end
    cyc(1);
    chk("b_full_level", 64'(if_b.level), 64'd8);
    chk("b_full_ready", 64'(if_b.s_ready), 64'd0);
    chk("b_full_busy",  64'(if_b.busy), 64'd1);
    chk("b_full_en",    64'(if_b.sh_en), 64'd0);
    cyc(1);
    chk("b_pop_level", 64'(if_b.level), 64'd7);
    chk("b_pop_en",    64'(if_b.sh_en), 64'd1);
    chk("b_pop_data",  64'(if_b.sh_data), 64'h2AA);
    chk("b_pop_ready", 64'(if_b.s_ready), 64'd1);
    if_b.s_valid = 1'b0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_feed_buf.md
Name: shift_feed_buf

Overview:
- Upstream feeder for the shift register stage.
- Accepts words from a producer over a valid/ready handshake and buffers them in a small circular FIFO.
- Once THRESH words are buffered, releases them back-to-back as a data word plus an enable strobe, one word per cycle, which drive the shift register's data_in/en inputs.
- Turns bursty producer traffic into contiguous enabled bursts for the downstream stage.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 8, FIFO depth in words; power of two, ≥ 2.
- THRESH, 4, buffered-word count that starts a drain burst; 1 ≤ THRESH ≤ DEPTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- s_valid  input  1  producer word valid.
- s_data  input  WIDTH  producer word.
- s_ready  output  1  buffer can accept a word this cycle.
- sh_en  output  1  registered strobe: sh_data holds a new word this cycle.
- sh_data  output  WIDTH  registered word to the downstream shift stage.
- level  output  $clog2(DEPTH)+1  registered count of buffered words, 0..DEPTH.
- busy  output  1  high while the FSM is in DRAIN.
- drained  output  1  one-cycle pulse when a burst empties the buffer.

Behaviour:
- Reset values:
  - level 0, read/write pointers 0, FSM state IDLE.
  - sh_en 0, sh_data 0, busy 0, drained 0.
  - s_ready is forced 0 while rst is high.
  - Buffered contents are discarded on reset; reset mid-burst aborts the burst immediately.
- s_ready is combinational: (level != DEPTH) && !rst.
- push = s_valid && s_ready. On push, s_data is written at wr_ptr and wr_ptr increments modulo DEPTH.
- s_valid while full: the word is not accepted and no state changes. The producer must hold the word.
- pop = (state == DRAIN) && (level != 0). On pop:
  - the word at rd_ptr is registered into sh_data and sh_en = 1 for the next cycle;
  - rd_ptr increments modulo DEPTH.
- When there is no pop: sh_en = 0 and sh_data holds its previous value.
- level update:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push and pop. A push in the same cycle as a pop of a full FIFO is impossible because s_ready = 0 when full.
  - level never exceeds DEPTH and never underflows.
- FSM, 2 states; busy = (state == DRAIN):
  - IDLE → DRAIN when registered level ≥ THRESH. The transition uses the current level, not the incoming push.
  - DRAIN stays in DRAIN while words remain, so pushes during DRAIN extend the burst.
  - DRAIN → IDLE on the edge where pop && level == 1 && !push. drained pulses high for exactly the following cycle.
- Latency:
  - Word accepted at edge e. If level reaches THRESH at e, state becomes DRAIN at e+1.
  - First sh_en = 1 is seen after edge e+2.
- Ordering: strict FIFO; words leave in acceptance order.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are determined only by level.
- THRESH = DEPTH: the burst starts only when full; s_ready stays low until the first pop.
- Words below THRESH remain in IDLE indefinitely; there is no timeout.

Test Plan:
- Reset then idle: rst 2 cycles → s_ready 1, level 0, sh_en 0, sh_data 0, busy 0 throughout 10 idle cycles.
- Threshold burst: push 0x11,0x22,0x33,0x44 on consecutive cycles (THRESH = 4) → busy rises 1 cycle after the 4th push. sh_en is high for exactly 4 consecutive cycles carrying 0x11..0x44 in order. drained pulses once; level returns to 0.
- Below threshold: push 3 words then stop → busy stays 0, sh_en never asserts, level holds 3. A 4th push triggers the full 4-word burst.
- Full/backpressure: hold s_valid high with 0x100+n for 12 cycles (DEPTH = 8) → no word lost or duplicated; sh_en sequence is 0x100..0x10B in order. s_ready stays 1 under this stream because the drain frees a slot every cycle. Separately, 9 pushes in IDLE with THRESH = 8 → s_ready 0 after the 8th word and level = 8.
- Simultaneous push/pop and wrap: sustain push during DRAIN for 20 words → level constant during overlap, pointers wrap ≥ 2 times, output order is preserved, single drained pulse at the end.
- Reset mid-burst: assert rst after 2 of 4 burst words have been output → next cycle sh_en 0, level 0, busy 0, drained 0. The remaining words are never emitted.
